// File: rtl/cam_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// cam_pkg: shared types for the camera power-up init sequencer
// Rev 1.0
// ---------------------------------------------------------------
package cam_pkg;

  localparam int CAM_REG_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DELAY    = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAIL     = 3'd6
  } cam_init_state_t;

  typedef struct packed {
    logic [CAM_REG_W-1:0] addr;
    logic [CAM_REG_W-1:0] data;
    logic                 delay;
    logic                 last;
  } cam_init_entry_t;

  function automatic cam_init_entry_t cam_entry(
    input logic [CAM_REG_W-1:0] addr,
    input logic [CAM_REG_W-1:0] data,
    input logic                 delay,
    input logic                 last
  );
    cam_init_entry_t e;
    e.addr  = addr;
    e.data  = data;
    e.delay = delay;
    e.last  = last;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_init_rom.sv
`default_nettype none
// ---------------------------------------------------------------
// cam_init_rom: register/value table, registered read (1 cycle)
// Rev 1.0
// ---------------------------------------------------------------
module cam_init_rom
  import cam_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic             clock,
  input  logic [IDX_W-1:0] idx,
  output cam_init_entry_t  entry
);

  cam_init_entry_t w_entry;

  // Unused slots read back as zero with last set, so a runaway index terminates.
  always_comb begin
    w_entry = cam_entry(8'h00, 8'h00, 1'b0, 1'b1);
    case (int'(idx))
      0:       w_entry = cam_entry(8'h12, 8'h80, 1'b0, 1'b0);
      1:       w_entry = cam_entry(8'h11, 8'h01, 1'b0, 1'b0);
      2:       w_entry = cam_entry(8'h0C, 8'h04, 1'b1, 1'b0);
      3:       w_entry = cam_entry(8'h3A, 8'h0D, 1'b0, 1'b1);
      default: w_entry = cam_entry(8'h00, 8'h00, 1'b0, 1'b1);
    endcase
  end

  always_ff @(posedge clock) begin
    entry <= w_entry;
  end

endmodule
`default_nettype wire

// File: rtl/cam_init_seq.sv
`default_nettype none
// ---------------------------------------------------------------
// cam_init_seq: walks the init table, issuing SCCB writes with retry
// Rev 1.0
// ---------------------------------------------------------------
module cam_init_seq
  import cam_pkg::*;
#(
  parameter int NUM_ENTRIES    = 16,
  parameter int DELAY_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 2,
  localparam int IDX_W         = $clog2(NUM_ENTRIES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 init,
  output logic                 done_init,
  output logic                 error,
  output logic [IDX_W-1:0]     err_index,
  output logic                 busy,
  output logic                 wr_valid,
  output logic [CAM_REG_W-1:0] wr_addr,
  output logic [CAM_REG_W-1:0] wr_data,
  input  logic                 wr_ready,
  input  logic                 wr_done,
  input  logic                 wr_nack
);

  localparam int TMAX    = (TIMEOUT_CYCLES > DELAY_CYCLES) ? TIMEOUT_CYCLES : DELAY_CYCLES;
  localparam int TIMER_W = $clog2(TMAX);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DELAY_LAST   = TIMER_W'(DELAY_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(NUM_ENTRIES - 1);

  cam_init_state_t      r_state;
  cam_init_state_t      w_next;
  cam_init_state_t      w_advance_st;
  cam_init_state_t      w_failure_st;
  cam_init_entry_t      w_entry;
  logic [IDX_W-1:0]     r_idx;
  logic [RETRY_W-1:0]   r_retry;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_error;
  logic [IDX_W-1:0]     r_err_index;
  logic                 w_timeout;
  logic                 w_delay_end;

  cam_init_rom #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_rom (
    .clock (clock),
    .idx   (r_idx),
    .entry (w_entry)
  );

  assign w_timeout    = (r_timer == TIMEOUT_LAST);
  assign w_delay_end  = (r_timer == DELAY_LAST);
  assign w_advance_st = (w_entry.last || (r_idx == IDX_LAST)) ? ST_DONE : ST_FETCH;
  assign w_failure_st = (r_retry < RETRY_LIMIT) ? ST_ISSUE : ST_FAIL;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a wr_done on the timeout cycle takes precedence
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (init) begin
          w_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (wr_ready) begin
          w_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (wr_done) begin
          if (wr_nack) begin
            w_next = w_failure_st;
          end else if (w_entry.delay) begin
            w_next = ST_DELAY;
          end else begin
            w_next = w_advance_st;
          end
        end else if (w_timeout) begin
          w_next = w_failure_st;
        end
      end
      ST_DELAY: begin
        if (w_delay_end) begin
          w_next = w_advance_st;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      ST_FAIL: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Counters and sticky error, stepped by the transition being taken
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx       <= '0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_error     <= 1'b0;
      r_err_index <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (init) begin
            r_idx       <= '0;
            r_retry     <= '0;
            r_error     <= 1'b0;
            r_err_index <= '0;
          end
        end
        ST_ISSUE: begin
          r_timer <= '0;
        end
        ST_WAIT_ACK: begin
          r_timer <= r_timer + TIMER_W'(1);
          if (w_next == ST_ISSUE) begin
            r_retry <= r_retry + RETRY_W'(1);
          end else if (w_next == ST_DELAY) begin
            r_timer <= '0;
          end else if (w_next == ST_FETCH) begin
            r_idx   <= r_idx + IDX_W'(1);
            r_retry <= '0;
          end
        end
        ST_DELAY: begin
          r_timer <= r_timer + TIMER_W'(1);
          if (w_next == ST_FETCH) begin
            r_idx   <= r_idx + IDX_W'(1);
            r_retry <= '0;
          end
        end
        ST_FAIL: begin
          r_error     <= 1'b1;
          r_err_index <= r_idx;
        end
        default: begin
          r_timer <= r_timer;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state and ROM data
  always_comb begin
    busy      = (r_state != ST_IDLE);
    wr_valid  = (r_state == ST_ISSUE);
    done_init = (r_state == ST_DONE);
    wr_addr   = '0;
    wr_data   = '0;
    if (r_state == ST_ISSUE) begin
      wr_addr = w_entry.addr;
      wr_data = w_entry.data;
    end
  end

  assign error     = r_error;
  assign err_index = r_err_index;

endmodule
`default_nettype wire
